// File: rtl/unidade_despacho_pkg.sv
// Shared opcode, class and field definitions for the in-order dispatch stage.
package unidade_despacho_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;

  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd1;
  localparam logic [1:0] CLS_MEM = 2'd2;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    KIND_NOP,
    KIND_EXEC,
    KIND_ILLEGAL
  } kind_e;

  function automatic kind_e op_kind(input logic [3:0] op);
    case (op)
      OP_NOP:                                 return KIND_NOP;
      OP_ADD, OP_SUB, OP_MUL, OP_LD, OP_ST:   return KIND_EXEC;
      default:                                return KIND_ILLEGAL;
    endcase
  endfunction

  function automatic logic [1:0] op_class(input logic [3:0] op);
    case (op)
      OP_MUL:       return CLS_MUL;
      OP_LD, OP_ST: return CLS_MEM;
      default:      return CLS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/unidade_despacho_fila_circular.sv
// Parameterised DEPTH x W circular FIFO with synchronous flush; flush beats push/pop.
module fila_circular #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/unidade_despacho.sv
// In-order issue stage: buffers fetched instructions and dispatches the head to ADD/MUL/MEM stations.
// Optional issue/stall counters are enabled with `define UNIDADE_DESPACHO_STATS_EN.
module unidade_despacho
  import unidade_despacho_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic [15:0]      Instrucao,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rs_add_full,
  input  logic             rs_mul_full,
  input  logic             rs_mem_full,
  output logic             issue_valid,
  output logic [1:0]       issue_class,
  output logic [3:0]       issue_op,
  output logic [2:0]       issue_rd,
  output logic [2:0]       issue_rs1,
  output logic [2:0]       issue_rs2,
  output logic [5:0]       issue_imm,
  output logic             illegal,
`ifdef UNIDADE_DESPACHO_STATS_EN
  output logic [15:0]      issued_cnt,
  output logic [15:0]      stall_cnt,
`endif
  output logic [PTR_W:0]   count
);

  logic [15:0] head;
  logic        fifo_full, fifo_empty, push, pop;
  logic [3:0]  head_op;
  logic [1:0]  head_cls;
  kind_e       head_kind;
  logic        target_full, active, blocked, do_issue;

  logic       issue_valid_q, issue_valid_d;
  logic [1:0] issue_class_q, issue_class_d;
  logic [3:0] issue_op_q, issue_op_d;
  logic [2:0] issue_rd_q, issue_rd_d;
  logic [2:0] issue_rs1_q, issue_rs1_d;
  logic [2:0] issue_rs2_q, issue_rs2_d;
  logic [5:0] issue_imm_q, issue_imm_d;
  logic       illegal_q, illegal_d;

  assign in_ready = !Reset && !fifo_full;
  assign push     = in_valid && in_ready && !Flush;

  fila_circular #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(16)) u_fila (
    .Clock (Clock),
    .Reset (Reset),
    .flush (Flush),
    .push  (push),
    .pop   (pop),
    .din   (Instrucao),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A blocked head stalls the whole queue; NOP and illegal words always drain.
  always_comb begin
    head_op   = head[OP_HI:OP_LO];
    head_kind = op_kind(head_op);
    head_cls  = op_class(head_op);
    case (head_cls)
      CLS_ADD: target_full = rs_add_full;
      CLS_MUL: target_full = rs_mul_full;
      default: target_full = rs_mem_full;
    endcase
    active   = !fifo_empty && !Flush;
    blocked  = active && (head_kind == KIND_EXEC) && target_full;
    do_issue = active && (head_kind == KIND_EXEC) && !target_full;
    pop      = active && !blocked;
  end

  always_comb begin
    issue_valid_d = do_issue;
    illegal_d     = active && (head_kind == KIND_ILLEGAL);
    issue_class_d = issue_class_q;
    issue_op_d    = issue_op_q;
    issue_rd_d    = issue_rd_q;
    issue_rs1_d   = issue_rs1_q;
    issue_rs2_d   = issue_rs2_q;
    issue_imm_d   = issue_imm_q;
    if (do_issue) begin
      issue_class_d = head_cls;
      issue_op_d    = head_op;
      issue_rd_d    = head[RD_HI:RD_LO];
      issue_rs1_d   = head[RS1_HI:RS1_LO];
      issue_rs2_d   = head[RS2_HI:RS2_LO];
      issue_imm_d   = (head_cls == CLS_MEM) ? head[IMM_HI:IMM_LO] : 6'd0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      issue_valid_q <= 1'b0;
      issue_class_q <= '0;
      issue_op_q    <= '0;
      issue_rd_q    <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
      issue_imm_q   <= '0;
      illegal_q     <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_class_q <= issue_class_d;
      issue_op_q    <= issue_op_d;
      issue_rd_q    <= issue_rd_d;
      issue_rs1_q   <= issue_rs1_d;
      issue_rs2_q   <= issue_rs2_d;
      issue_imm_q   <= issue_imm_d;
      illegal_q     <= illegal_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_class = issue_class_q;
  assign issue_op    = issue_op_q;
  assign issue_rd    = issue_rd_q;
  assign issue_rs1   = issue_rs1_q;
  assign issue_rs2   = issue_rs2_q;
  assign issue_imm   = issue_imm_q;
  assign illegal     = illegal_q;

`ifdef UNIDADE_DESPACHO_STATS_EN
  // Saturating counters survive Flush; only Reset clears them.
  logic [15:0] issued_cnt_q, issued_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issued_cnt_d = issued_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (do_issue && issued_cnt_q != 16'hFFFF) issued_cnt_d = issued_cnt_q + 16'd1;
    if (blocked && stall_cnt_q != 16'hFFFF)   stall_cnt_d  = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign issued_cnt = issued_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_unidade_despacho.sv
// Scoreboard bench for unidade_despacho: directed cases then randomized traffic against a queue model.
module tb_unidade_despacho;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic [15:0] Instrucao = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        rs_add_full = 1'b0, rs_mul_full = 1'b0, rs_mem_full = 1'b0;
  logic        issue_valid;
  logic [1:0]  issue_class;
  logic [3:0]  issue_op;
  logic [2:0]  issue_rd, issue_rs1, issue_rs2;
  logic [5:0]  issue_imm;
  logic        illegal;
  logic [2:0]  count;
`ifdef UNIDADE_DESPACHO_STATS_EN
  logic [15:0] issued_cnt, stall_cnt;
  int          issued_m = 0, stall_m = 0;
`endif

  unidade_despacho #(.DEPTH(4), .PTR_W(2)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Flush       (Flush),
    .Instrucao   (Instrucao),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs_add_full (rs_add_full),
    .rs_mul_full (rs_mul_full),
    .rs_mem_full (rs_mem_full),
    .issue_valid (issue_valid),
    .issue_class (issue_class),
    .issue_op    (issue_op),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_imm   (issue_imm),
    .illegal     (illegal),
`ifdef UNIDADE_DESPACHO_STATS_EN
    .issued_cnt  (issued_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .count       (count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit         ill;
    logic [1:0] cls;
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [5:0] imm;
    int         due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          cur_rst = 1'b1;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Opcode rules: 0 = NOP, 1..5 executable, everything above is illegal
  function automatic int kind_of(input logic [3:0] op);
    if (op == 4'd0) return 0;
    if (op <= 4'd5) return 1;
    return 2;
  endfunction

  function automatic logic [1:0] unit_of(input logic [3:0] op);
    if (op <= 4'd2) return 2'd0;
    if (op == 4'd3) return 2'd1;
    return 2'd2;
  endfunction

  task automatic check_output();
    cmp("count", int'(count), model_q.size());
    cmp("in_ready", int'(in_ready), (!cur_rst && model_q.size() < 4) ? 1 : 0);
    if (cur_rst)
      cmp("reset_outputs", int'({issue_valid, illegal, issue_class, issue_op,
                                 issue_rd, issue_rs1, issue_rs2, issue_imm}), 0);
`ifdef UNIDADE_DESPACHO_STATS_EN
    cmp("issued_cnt", int'(issued_cnt), issued_m);
    cmp("stall_cnt", int'(stall_cnt), stall_m);
`endif
  endtask

  task automatic apply_stimulus(input bit rst, input bit fl, input bit vld,
                                input logic [15:0] ins, input bit af,
                                input bit mf, input bit mmf);
    exp_t e;
    int   n;
    bit   full_flag;
    logic [15:0] h;
    @(negedge Clock);
    #1;
    check_output();
    Reset = rst; Flush = fl; in_valid = vld; Instrucao = ins;
    rs_add_full = af; rs_mul_full = mf; rs_mem_full = mmf;
    if (rst) begin
      model_q.delete();
`ifdef UNIDADE_DESPACHO_STATS_EN
      issued_m = 0; stall_m = 0;
`endif
    end else if (fl) begin
      model_q.delete();
    end else begin
      n = model_q.size();
      if (n > 0) begin
        h = model_q[0];
        case (kind_of(h[15:12]))
          0: void'(model_q.pop_front());
          1: begin
            case (unit_of(h[15:12]))
              2'd0:    full_flag = af;
              2'd1:    full_flag = mf;
              default: full_flag = mmf;
            endcase
            if (full_flag) begin
`ifdef UNIDADE_DESPACHO_STATS_EN
              if (stall_m < 65535) stall_m++;
`endif
            end else begin
              void'(model_q.pop_front());
              e.ill = 1'b0; e.cls = unit_of(h[15:12]); e.op = h[15:12];
              e.rd = h[11:9]; e.rs1 = h[8:6]; e.rs2 = h[5:3];
              e.imm = (h[15:12] == 4'd4 || h[15:12] == 4'd5) ? h[5:0] : 6'd0;
              e.due = cyc + 1;
              exp_q.push_back(e);
`ifdef UNIDADE_DESPACHO_STATS_EN
              if (issued_m < 65535) issued_m++;
`endif
            end
          end
          default: begin
            void'(model_q.pop_front());
            e = '{ill: 1'b1, cls: 2'd0, op: 4'd0, rd: 3'd0, rs1: 3'd0,
                  rs2: 3'd0, imm: 6'd0, due: cyc + 1};
            exp_q.push_back(e);
          end
        endcase
      end
      if (vld && n < 4) model_q.push_back(ins);
    end
    cur_rst = rst;
  endtask

  // Monitor: consumes expectations whenever the DUT presents an issue or illegal pulse.
  always @(negedge Clock) begin
    exp_t m;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++; errors++;
      $display("[TB] FAIL missing_output: got none expected due at cycle %0d", exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (issue_valid || illegal) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL spurious_output: got valid=%0d illegal=%0d expected none at cycle %0d",
                 issue_valid, illegal, cyc);
      end else begin
        m = exp_q.pop_front();
        cmp("out_due_cycle", cyc, m.due);
        cmp("issue_valid", int'(issue_valid), m.ill ? 0 : 1);
        cmp("illegal", int'(illegal), m.ill ? 1 : 0);
        if (!m.ill) begin
          cmp("issue_class", int'(issue_class), int'(m.cls));
          cmp("issue_op", int'(issue_op), int'(m.op));
          cmp("issue_rd", int'(issue_rd), int'(m.rd));
          cmp("issue_rs1", int'(issue_rs1), int'(m.rs1));
          cmp("issue_rs2", int'(issue_rs2), int'(m.rs2));
          cmp("issue_imm", int'(issue_imm), int'(m.imm));
        end
      end
    end
  end

  task automatic idle(input int n, input bit af, input bit mf, input bit mmf);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 16'h0000, af, mf, mmf);
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  op;
    $display("[TB] start");
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 0);
    apply_stimulus(1, 0, 0, 16'h0000, 0, 0, 0);
    // Single ADD, earliest issue
    apply_stimulus(0, 0, 1, 16'h1298, 0, 0, 0);
    idle(2, 0, 0, 0);
    // Fill behind a full ADD station, then drain
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 16'h1298 + 16'(i), 1, 0, 0);
    apply_stimulus(0, 0, 1, 16'h12A0, 1, 0, 0);
    idle(6, 0, 0, 0);
    // MUL blocks a younger ADD
    apply_stimulus(0, 0, 1, 16'h3298, 0, 1, 0);
    apply_stimulus(0, 0, 1, 16'h1298, 0, 1, 0);
    idle(2, 0, 1, 0);
    idle(3, 0, 0, 0);
    // NOP, illegal, LD
    apply_stimulus(0, 0, 1, 16'h0000, 0, 0, 0);
    apply_stimulus(0, 0, 1, 16'hF000, 0, 0, 0);
    apply_stimulus(0, 0, 1, 16'h4285, 0, 0, 0);
    idle(3, 0, 0, 0);
    // Flush and Reset each with a simultaneous push
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 16'h1298, 1, 0, 0);
    apply_stimulus(0, 1, 1, 16'h1111, 1, 0, 0);
    idle(2, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 16'h5A3F, 0, 0, 1);
    apply_stimulus(1, 0, 1, 16'h1111, 0, 0, 1);
    idle(2, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      op = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) op = 4'hF;
      r = {op, 12'($urandom())};
      apply_stimulus($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 9) < 7, r,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) < 3);
    end
    idle(8, 0, 0, 0);
    @(negedge Clock);
    #1;
    cmp("drain_pending", exp_q.size(), 0);
    cmp("drain_count", int'(count), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
